pc_alu_branch_unit: RTL and testbench

PC_ALU_BRANCH_UNIT -- requirements
Module: pc_alu_branch_unit

---
 rtl/pc_alu_branch_unit.sv | 97 +++++++++
 tb/tb_pc_alu_branch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_alu_branch_unit.sv
// Program counter register, 32-bit ALU with flags, and combinational branch
// condition evaluation for a single-issue datapath.
module pc_alu_branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] jump_addr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  alu_op,
  input  logic [2:0]  branch_type,
  output logic [31:0] i_addr,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic        c_out,
  output logic        over,
  output logic        branch_taken
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_PASSA = 3'b110;
  localparam logic [2:0] OP_ZERO  = 3'b111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  logic [32:0] sum;
  logic [32:0] diff;

  // The PC wraps modulo 2^32; redirect targets are taken verbatim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_addr <= 32'h0000_0000;
    end else if (pc_src) begin
      i_addr <= jump_addr;
    end else begin
      i_addr <= i_addr + 32'd4;
    end
  end

  // Bit 32 of the subtract path is the "no borrow" carry, so c_out=1 means A>=B unsigned.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} + {1'b0, ~B} + 33'd1;

  always_comb begin
    result = 32'h0000_0000;
    c_out  = 1'b0;
    over   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        result = sum[31:0];
        c_out  = sum[32];
        over   = (A[31] == B[31]) && (sum[31] != A[31]);
      end
      OP_SUB: begin
        result = diff[31:0];
        c_out  = diff[32];
        over   = (A[31] != B[31]) && (diff[31] != A[31]);
      end
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_XOR:   result = A ^ B;
      OP_PASSB: result = B;
      OP_PASSA: result = A;
      OP_ZERO:  result = 32'h0000_0000;
      default:  result = 32'h0000_0000;
    endcase
  end

  assign zero = (result == 32'h0000_0000);
  assign neg  = result[31];

  // Codes 010 and 011 fall to the default and never branch.
  always_comb begin
    branch_taken = 1'b0;
    case (branch_type)
      BR_BEQ:  branch_taken = zero;
      BR_BNE:  branch_taken = ~zero;
      BR_BLT:  branch_taken = (neg != over);
      BR_BGE:  branch_taken = (neg == over);
      BR_BLTU: branch_taken = ~c_out;
      BR_BGEU: branch_taken = c_out;
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// Directed bench for pc_alu_branch_unit: a table of ALU/branch vectors plus
// hand-written PC sequences covering reset, redirect and wrap-around.
module tb_pc_alu_branch_unit;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [31:0] jump_addr;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  alu_op;
  logic [2:0]  branch_type;
  logic [31:0] i_addr;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        c_out;
  logic        over;
  logic        branch_taken;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  bt;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        o;
    logic        t;
  } vec_t;

  vec_t vecs[$];

  pc_alu_branch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_src       (pc_src),
    .jump_addr    (jump_addr),
    .A            (A),
    .B            (B),
    .alu_op       (alu_op),
    .branch_type  (branch_type),
    .i_addr       (i_addr),
    .result       (result),
    .zero         (zero),
    .neg          (neg),
    .c_out        (c_out),
    .over         (over),
    .branch_taken (branch_taken)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [2:0] bt,
                              input logic [31:0] res, input logic z, input logic n,
                              input logic c, input logic o, input logic t);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.bt = bt; v.res = res;
    v.z = z; v.n = n; v.c = c; v.o = o; v.t = t;
    return v;
  endfunction

  // Advance one rising edge, then compare i_addr against the scoreboard head.
  task automatic pc_step(input string name);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: expected queue empty, got %h required entry", name, i_addr);
    end else begin
      exp = exp_q.pop_front();
      check32(name, i_addr, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    pc_src      = 1'b1;
    jump_addr   = 32'h0000_0055;
    A           = 32'h0;
    B           = 32'h0;
    alu_op      = 3'b000;
    branch_type = 3'b010;

    // Reset dominates pc_src across several edges
    #1;
    check32("reset_immediate", i_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check32("reset_holds", i_addr, 32'h0);

    // Sequential count after reset release
    reset  = 1'b1;
    pc_src = 1'b0;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    pc_step("seq_4");
    pc_step("seq_8");
    pc_step("seq_c");

    // Mid-cycle asynchronous reset
    #2;
    reset = 1'b0;
    #1;
    check32("async_reset_mid", i_addr, 32'h0);
    #1;
    reset = 1'b1;
    exp_q.push_back(32'h4);
    pc_step("first_after_reset");

    // Redirect then sequential
    pc_src    = 1'b1;
    jump_addr = 32'h0000_0100;
    exp_q.push_back(32'h100);
    pc_step("jump_100");
    pc_src = 1'b0;
    exp_q.push_back(32'h104);
    pc_step("after_jump_104");

    // Unaligned target loaded verbatim
    pc_src    = 1'b1;
    jump_addr = 32'h0000_0003;
    exp_q.push_back(32'h3);
    pc_step("jump_unaligned");
    pc_src = 1'b0;
    exp_q.push_back(32'h7);
    pc_step("unaligned_plus4");

    // Wrap-around at the top of the address space
    pc_src    = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    pc_step("jump_top");
    pc_src = 1'b0;
    exp_q.push_back(32'h0);
    pc_step("wrap_zero");

    // First edge after reset with a redirect pending
    reset = 1'b0;
    #1;
    check32("reset_again", i_addr, 32'h0);
    reset     = 1'b1;
    pc_src    = 1'b1;
    jump_addr = 32'h0000_0200;
    exp_q.push_back(32'h200);
    pc_step("first_after_reset_jump");
    pc_src = 1'b0;

    // ALU / branch vectors:   A             B             op      bt      result        z     n     c     o     taken
    vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 3'b100, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b001, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b001, 3'b001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b001, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b001, 3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 3'b100, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 3'b101, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b001, 3'b111, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0003, 32'h0000_0005, 3'b001, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0001, 3'b001, 3'b100, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0001, 3'b001, 3'b101, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 3'b001, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h1234_0000, 32'h0000_5678, 3'b011, 3'b010, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'b100, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'b100, 3'b011, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0001, 32'h8000_0000, 3'b101, 3'b100, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'hDEAD_BEEF, 32'h0000_0001, 3'b110, 3'b101, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 3'b111, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 3'b000, 3'b100, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));

    foreach (vecs[i]) begin
      A           = vecs[i].a;
      B           = vecs[i].b;
      alu_op      = vecs[i].op;
      branch_type = vecs[i].bt;
      #1;
      total++;
      if (result !== vecs[i].res) begin
        bad++;
        $display("FAIL result[%0d]: got %h expected %h", i, result, vecs[i].res);
      end
      check1("zero", i, zero, vecs[i].z);
      check1("neg", i, neg, vecs[i].n);
      check1("c_out", i, c_out, vecs[i].c);
      check1("over", i, over, vecs[i].o);
      check1("branch_taken", i, branch_taken, vecs[i].t);
    end

    // Combinational outputs stay live while the PC is held in reset
    reset       = 1'b0;
    A           = 32'h0000_0009;
    B           = 32'h0000_0009;
    alu_op      = 3'b001;
    branch_type = 3'b000;
    #1;
    check32("alu_during_reset", result, 32'h0);
    check1("beq_during_reset", 0, branch_taken, 1'b1);
    check32("pc_during_reset", i_addr, 32'h0);
    reset = 1'b1;

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL exp_q_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
